// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are active-high, bit order g..a.
package seg7_pkg;

    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Entry k is the pattern for hex digit k (listed F down to 0).
    localparam logic [15:0][6:0] HEX_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_lut.sv
// Hex nibble to active-high seven-segment pattern.
// Pure combinational lookup, one instance on the muxed digit.
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    // Table lookup of the segment pattern.
    always_comb begin
        pat = HEX_PAT[nib];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver, double-buffered data.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_LOW = (DIG_ACTIVE_LOW != 0);

    localparam logic [7:0] SEG_IDLE =
        SEG_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] DIG_IDLE =
        DIG_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] nib_disp_q, nib_disp_d;
    logic [DIGITS-1:0]   dp_disp_q, dp_disp_d;
    logic [4*DIGITS-1:0] nib_pend_q, nib_pend_d;
    logic [DIGITS-1:0]   dp_pend_q, dp_pend_d;
    logic                pend_q, pend_d;
    logic                fdone_q, fdone_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;

    logic                tick;
    logic                wrap;
    logic [3:0]          nib_mux;
    logic                dp_mux;
    logic [6:0]          lut_pat;
    logic                lzb_off;
    logic                dark;
    logic [7:0]          seg_int;
    logic [DIGITS-1:0]   dig_hot;

    assign tick = (presc_q == PRESC_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);

    assign nib_mux = nib_disp_q[{idx_q, 2'b00} +: 4];
    assign dp_mux  = dp_disp_q[idx_q];

    seg7_hex_lut u_lut (
        .nib (nib_mux),
        .pat (lut_pat)
    );

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] sup_vec;
    logic              lead;

    // Suppress zero digits from the top down until a shown digit.
    always_comb begin
        sup_vec = '0;
        lead    = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead = lead
                && (nib_disp_q[4*i +: 4] == 4'h0)
                && !dp_disp_q[i];
            sup_vec[i] = lead;
        end
    end

    assign lzb_off = sup_vec[idx_q];
`else
    assign lzb_off = 1'b0;
`endif

    // Scan counters, buffer handoff and registered pin values.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        nib_disp_d = nib_disp_q;
        dp_disp_d  = dp_disp_q;
        nib_pend_d = nib_pend_q;
        dp_pend_d  = dp_pend_q;
        pend_d     = pend_q;
        fdone_d    = wrap;

        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        // Commit old pending contents before a same-cycle load.
        if (wrap && pend_q) begin
            nib_disp_d = nib_pend_q;
            dp_disp_d  = dp_pend_q;
            pend_d     = 1'b0;
        end

        if (load) begin
            nib_pend_d = data_in;
            dp_pend_d  = dp_in;
            pend_d     = 1'b1;
        end

        dark = (presc_q < BLANK_LIM) || blank || lzb_off;

        seg_int         = SEG_OFF;
        seg_int[SEG_DP] = dp_mux;
        seg_int[6:0]    = lut_pat;
        dig_hot         = DIGITS'(1) << idx_q;

        if (dark) begin
            seg_d = SEG_IDLE;
            dig_d = DIG_IDLE;
        end else begin
            seg_d = SEG_LOW ? ~seg_int : seg_int;
            dig_d = DIG_LOW ? ~dig_hot : dig_hot;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            nib_disp_q <= '0;
            dp_disp_q  <= '0;
            nib_pend_q <= '0;
            dp_pend_q  <= '0;
            pend_q     <= 1'b0;
            fdone_q    <= 1'b0;
            seg_q      <= SEG_IDLE;
            dig_q      <= DIG_IDLE;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            nib_disp_q <= nib_disp_d;
            dp_disp_q  <= dp_disp_d;
            nib_pend_q <= nib_pend_d;
            dp_pend_q  <= dp_pend_d;
            pend_q     <= pend_d;
            fdone_q    <= fdone_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = fdone_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver, 4 digits, 4-cycle slots.
// Expected segment codes are hand-computed active-low values.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int errors = 0;
    int fid    = 0;
    logic p_exp = 1'b0;

    seg7_scan_driver #(
        .DIGITS         (4),
        .CLK_DIV        (4),
        .BLANK_CYC      (1),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank      (blank),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    // One full frame starting at slot 0 cycle 0.
    // codes: {d3,d2,d1,d0}; dark: digits expected suppressed.
    task automatic run_frame(
        input logic [3:0][7:0] codes,
        input logic [3:0]      dark,
        input int              la,
        input logic [15:0]     da,
        input logic [3:0]      pa,
        input int              lb,
        input logic [15:0]     db,
        input logic [3:0]      pb,
        input int              bf,
        input int              bl);
        int         dg;
        int         sl;
        logic       ld;
        logic       off;
        logic [3:0] one;
        logic [7:0] e_seg;
        logic [3:0] e_dig;
        for (int i = 0; i < 16; i++) begin
            ld = 1'b0;
            if (i == la) begin
                load = 1'b1; data_in = da; dp_in = pa; ld = 1'b1;
            end
            if (i == lb) begin
                load = 1'b1; data_in = db; dp_in = pb; ld = 1'b1;
            end
            blank = (i >= bf) && (i < bf + bl);
            cyc();
            if (i == 15) p_exp = 1'b0;
            if (ld) p_exp = 1'b1;
            dg  = i / 4;
            sl  = i % 4;
            off = (sl == 0) || blank || dark[dg];
            one = 4'b0001 << dg;
            e_seg = off ? 8'hFF : codes[dg];
            e_dig = off ? 4'hF : ~one;
            chk($sformatf("f%0d c%0d seg", fid, i), 32'(seg_out), 32'(e_seg));
            chk($sformatf("f%0d c%0d dig", fid, i), 32'(dig_sel), 32'(e_dig));
            chk($sformatf("f%0d c%0d fdone", fid, i),
                32'(frame_done), 32'(i == 15));
            chk($sformatf("f%0d c%0d pend", fid, i),
                32'(pending), 32'(p_exp));
        end
        blank = 1'b0;
        fid++;
    endtask

    localparam int NO = -1;

    initial begin
        logic [3:0] lzd;
`ifdef SEG7_LZB_EN
        lzd = 4'b1100;
`else
        lzd = 4'b0000;
`endif
        rst = 1'b1; data_in = '0; dp_in = '0;
        load = 1'b0; blank = 1'b0;
        repeat (3) cyc();
        chk("rst seg", 32'(seg_out), 32'hFF);
        chk("rst dig", 32'(dig_sel), 32'hF);
        chk("rst fdone", 32'(frame_done), 32'h0);
        chk("rst pend", 32'(pending), 32'h0);
        rst = 1'b0;

        // Idle zeros, then load A81F, then two loads (last wins).
        run_frame({4{8'hC0}}, 4'h0, NO, '0, '0, NO, '0, '0, 99, 0);
        run_frame({4{8'hC0}}, 4'h0, 0, 16'hA81F, 4'h0,
                  NO, '0, '0, 99, 0);
        run_frame({8'h88, 8'h80, 8'hF9, 8'h8E}, 4'h0,
                  2, 16'h1111, 4'h0, 7, 16'h2222, 4'h0, 99, 0);
        // Load on the wrap tick plus a 5-cycle blank burst.
        run_frame({4{8'hA4}}, 4'h0, 0, 16'h3333, 4'h0,
                  15, 16'h4444, 4'h0, 99, 0);
        run_frame({4{8'hB0}}, 4'h0, NO, '0, '0, NO, '0, '0, 5, 5);
        run_frame({4{8'h99}}, 4'h0, 0, 16'h0050, 4'h0,
                  NO, '0, '0, 99, 0);
        // Leading zeros, then a lit dp on the top digit.
        run_frame({8'hC0, 8'hC0, 8'h92, 8'hC0}, lzd,
                  0, 16'h0050, 4'b1000, NO, '0, '0, 99, 0);
        run_frame({8'h40, 8'hC0, 8'h92, 8'hC0}, 4'h0,
                  NO, '0, '0, NO, '0, '0, 99, 0);

        // Reset mid-frame drops pending data and display.
        load = 1'b1; data_in = 16'h5555; dp_in = 4'h0;
        cyc();
        cyc();
        chk("pre-rst pend", 32'(pending), 32'h1);
        rst = 1'b1;
        cyc();
        chk("mid rst seg", 32'(seg_out), 32'hFF);
        chk("mid rst dig", 32'(dig_sel), 32'hF);
        chk("mid rst pend", 32'(pending), 32'h0);
        rst = 1'b0;
        p_exp = 1'b0;
        run_frame({4{8'hC0}}, 4'h0, NO, '0, '0, NO, '0, '0, 99, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver. It accepts a packed vector of 4-bit hex nibbles plus per-digit decimal points and decodes each nibble to segment patterns (0–F). It scans the digits one at a time with a programmable slot period and anti-ghosting blank guard. New data is double-buffered so it commits only at frame boundaries. The block sits between the board-level value/status logic and the display pins, superseding the single-digit combinational decoder.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned (1..8).
- CLK_DIV, 50000: clk cycles per digit slot (≥2).
- BLANK_CYC, 2: cycles at the start of each slot with all outputs inactive (0 ≤ BLANK_CYC < CLK_DIV).
- SEG_ACTIVE_LOW, 1: 1 means segment/dp pins are active-low.
- DIG_ACTIVE_LOW, 1: 1 means digit-select pins are active-low.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- data_in, in, 4*DIGITS: nibble k at [4k+3:4k]; digit 0 is least significant.
- dp_in, in, DIGITS: decimal point per digit; 1 means lit.
- load, in, 1: single-cycle strobe that captures data_in/dp_in into the pending buffer.
- blank, in, 1: global blank; 1 forces all outputs inactive.
- seg_out, out, 8: bit 7 is dp, bits 6:0 are segments g..a.
- dig_sel, out, DIGITS: one-hot digit enable at the configured polarity.
- frame_done, out, 1: one-cycle pulse when the scan wraps to digit 0.
- pending, out, 1: high while captured data awaits commit.

## Operation
- Prescaler counts 0..CLK_DIV-1, then wraps. `tick` is asserted when it equals CLK_DIV-1.
- On `tick`, the digit index increments; it wraps from DIGITS-1 to 0.
- Wrap event (tick with index = DIGITS-1):
  - frame_done pulses on the next cycle.
  - If `pending` is set, the pending buffer copies into the display registers and `pending` clears, in the same cycle as the wrap.
- `load`:
  - Sets `pending` and overwrites the pending buffer, including when `pending` is already set (last write wins).
  - If `load` coincides with a wrap commit, the old pending contents commit. The new data is captured and `pending` stays 1.
- Decode uses the standard hex patterns in internal active-high form: 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71. Outputs are inverted when the corresponding ACTIVE_LOW parameter is 1.
- Active digit k drives seg_out = {dp_disp[k], pattern(nib_disp[k])} and dig_sel bit k active. All other dig_sel bits are inactive.
- Outputs are inactive (all segments off, no digit selected) when any of the following holds:
  - the prescaler is below BLANK_CYC,
  - `blank` is 1,
  - the digit is suppressed by LZB.
- Reset:
  - prescaler and index are 0.
  - Display registers and pending buffer are 0; `pending` is 0.
  - seg_out and dig_sel are at their inactive levels.
  - frame_done is 0.
- Reset mid-frame drops any pending data; the scan restarts at digit 0, slot cycle 0.

## Timing
- All outputs are registered: one cycle from prescaler/index/data state to the pins.
- Slot length is CLK_DIV cycles; frame length is DIGITS*CLK_DIV cycles.
- Lit time per slot is CLK_DIV-BLANK_CYC cycles.
- Latency from `load` to first visible digit 0: from 1 cycle to one frame, plus BLANK_CYC+1 cycles.
- `blank` takes effect on the pins one cycle after it is asserted; it does not stop the scan.

## Configuration
- SEG7_LZB_EN defined:
  - Leading-zero blanking is enabled.
  - Starting at digit DIGITS-1 and moving downward, digits whose committed nibble is 0 and dp is 0 are suppressed until the first digit with a nonzero nibble or dp=1.
  - Digit 0 is never suppressed.
- SEG7_LZB_EN undefined: all digits are always shown. The suppression logic is absent.

## Structure
- Package seg7_pkg:
  - the 16-entry hex pattern constants (active-high),
  - the SEG_DP bit index,
  - the off-pattern constant.
- Sub-module seg7_hex_lut: combinational 4-bit to 7-bit active-high pattern, instantiated once on the muxed nibble.
- The top level contains the prescaler, index, double buffer, LZB logic and output registers.

## Test plan
Bench settings: DIGITS=4, CLK_DIV=4, BLANK_CYC=1, both polarities active-low.

- Reset, then idle → seg_out=0xFF and dig_sel=4'hF while rst is high. After release, digit 0 shows 0xC0 with dig_sel=4'hE.
- load with data_in=16'hA81F, dp_in=0 → after the commit, slots show F=0x8E, 1=0xF9, 8=0x80, A=0x88. dig_sel cycles E, D, B, 7. Each slot's first cycle is 0xFF/F. frame_done pulses every 16 cycles.
- Two loads mid-frame (16'h1111, then 16'h2222) → only 16'h2222 is ever displayed. `pending` stays high until the wrap, then drops.
- load coincident with the wrap tick → the old pending data commits, `pending` stays 1, and the new data appears one frame later.
- blank held for 5 cycles → pins stay 0xFF/F with a 1-cycle lag. The scan index continues, so the next digit after release matches free-running.
- With SEG7_LZB_EN defined, data 16'h0050 with dp_in=0 → digits 3 and 2 stay dark for their whole slot; digits 1 and 0 show 0x92 (5) and 0xC0 (0). With dp_in=4'b1000 → digit 3 shows 0x40 (0 with dp lit).
